activate_dense_reg: RTL and testbench

- Return-path stage register that carries backprop results from the activate stage back to the dense stage.
- It is the reverse direction of the forward dense-to-activate register stage.
- It replaces the forward path's self-timed clk_out chaining with a registered valid/ready handshake and a small FIFO, so the activate stage can emit bursts while the dense stage stalls on weight updates.

---
 rtl/nb_reg_pkg.sv | 32 +++
 rtl/reg_fifo_mem.sv | 33 +++
 rtl/activate_dense_reg.sv | 134 +++++++++++++
 tb/tb_activate_dense_reg.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nb_reg_pkg.sv
// Shared types for the activate-to-dense return-path register.
// Holds the index width, the tag typedefs and the packed FIFO entry layout.
package nb_reg_pkg;

  localparam int INDEX_W         = 32;
  localparam int ACT_TYPE_SIZE   = 4;
  localparam int DENSE_TYPE_SIZE = 4;
  localparam int SIZE            = 3;
  localparam int DATA_SIZE       = 16;
  localparam int GRAD_W          = SIZE * DATA_SIZE;

  typedef logic [ACT_TYPE_SIZE-1:0]   act_type_t;
  typedef logic [DENSE_TYPE_SIZE-1:0] dense_type_t;

  typedef struct packed {
    act_type_t          act_type;
    dense_type_t        dense_type;
    logic [GRAD_W-1:0]  grad;
    logic [INDEX_W-1:0] w_layer_index;
    logic [INDEX_W-1:0] w_row_index;
    logic               is_update;
    logic               backprop_cost;
  } bp_entry_t;

  localparam int ENTRY_W = $bits(bp_entry_t);

  // A beat is worth queuing only if it carries an update or a cost gradient.
  function automatic logic carries_payload(input logic is_update, input logic backprop_cost);
    return is_update | backprop_cost;
  endfunction

endpackage

// File: rtl/reg_fifo_mem.sv
// Register-file storage for the return-path FIFO.
// One synchronous write port, one asynchronous read port; cleared on reset.
module reg_fifo_mem
  import nb_reg_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage array: zeroed on reset, written at wr_ptr when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/activate_dense_reg.sv
// Return-path stage register: carries backprop results from the activate
// stage to the dense stage through a small valid/ready FIFO so bursts from
// activate survive dense stalling on weight updates.
// Optional build macro ACT_DENSE_REG_STATS_EN adds xfer_count/drop_count.
module activate_dense_reg
  import nb_reg_pkg::*;
#(
  parameter int size            = SIZE,
  parameter int data_size       = DATA_SIZE,
  parameter int depth           = 2,
  parameter int act_type_size   = ACT_TYPE_SIZE,
  parameter int dense_type_size = DENSE_TYPE_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [act_type_size-1:0]      act_type,
  input  logic [dense_type_size-1:0]    dense_type,
  input  logic [data_size*size-1:0]     grad,
  input  logic [INDEX_W-1:0]            w_layer_index,
  input  logic [INDEX_W-1:0]            w_row_index,
  input  logic                          is_update,
  input  logic                          backprop_cost,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [act_type_size-1:0]      act_type_out,
  output logic [dense_type_size-1:0]    dense_type_out,
  output logic [data_size*size-1:0]     grad_out,
  output logic [INDEX_W-1:0]            w_layer_index_out,
  output logic [INDEX_W-1:0]            w_row_index_out,
  output logic                          is_update_out,
  output logic                          backprop_cost_out,
  output logic [$clog2(depth+1)-1:0]    count
`ifdef ACT_DENSE_REG_STATS_EN
  ,
  output logic [31:0]                   xfer_count,
  output logic [31:0]                   drop_count
`endif
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             store;
  logic             pop;
  bp_entry_t        wr_entry;
  bp_entry_t        rd_entry;

  // Handshake is decided from registered occupancy only, so neither ready
  // nor valid has a combinational path from the other side.
  assign in_ready  = (count < CNT_W'(depth));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign store     = accept & carries_payload(is_update, backprop_cost);
  assign pop       = out_valid & out_ready;

  // Pack the incoming beat into the storage entry layout.
  always_comb begin
    wr_entry               = '0;
    wr_entry.act_type      = act_type;
    wr_entry.dense_type    = dense_type;
    wr_entry.grad          = grad;
    wr_entry.w_layer_index = w_layer_index;
    wr_entry.w_row_index   = w_row_index;
    wr_entry.is_update     = is_update;
    wr_entry.backprop_cost = backprop_cost;
  end

  // A flushed cycle discards its write so the entry never becomes visible.
  reg_fifo_mem #(
    .W     (ENTRY_W),
    .DEPTH (depth)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (store & ~flush),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_entry)
  );

  // Pointer and occupancy tracking; flush wins over any same-cycle traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry fields come straight from storage at rd_ptr.
  always_comb begin
    act_type_out      = rd_entry.act_type;
    dense_type_out    = rd_entry.dense_type;
    grad_out          = rd_entry.grad;
    w_layer_index_out = rd_entry.w_layer_index;
    w_row_index_out   = rd_entry.w_row_index;
    is_update_out     = rd_entry.is_update;
    backprop_cost_out = rd_entry.backprop_cost;
  end

`ifdef ACT_DENSE_REG_STATS_EN
  // Transfer and bubble-drop counters; only rst_n clears them, and traffic
  // discarded by a flush is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
      drop_count <= '0;
    end else if (!flush) begin
      if (pop)              xfer_count <= xfer_count + 32'd1;
      if (accept && !store) drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_activate_dense_reg.sv
// Self-checking bench for activate_dense_reg: directed steps followed by a
// randomized phase, compared each cycle against a queue-based model.
module tb_activate_dense_reg;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [3:0]  act;
    logic [3:0]  dense;
    logic [47:0] grad;
    logic [31:0] layer;
    logic [31:0] row;
    logic        upd;
    logic        cost;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  beat_t       cur = '0;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  act_type_out;
  logic [3:0]  dense_type_out;
  logic [47:0] grad_out;
  logic [31:0] w_layer_index_out;
  logic [31:0] w_row_index_out;
  logic        is_update_out;
  logic        backprop_cost_out;
  logic [1:0]  count;
`ifdef ACT_DENSE_REG_STATS_EN
  logic [31:0] xfer_count;
  logic [31:0] drop_count;
`endif

  activate_dense_reg dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .act_type          (cur.act),
    .dense_type        (cur.dense),
    .grad              (cur.grad),
    .w_layer_index     (cur.layer),
    .w_row_index       (cur.row),
    .is_update         (cur.upd),
    .backprop_cost     (cur.cost),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .act_type_out      (act_type_out),
    .dense_type_out    (dense_type_out),
    .grad_out          (grad_out),
    .w_layer_index_out (w_layer_index_out),
    .w_row_index_out   (w_row_index_out),
    .is_update_out     (is_update_out),
    .backprop_cost_out (backprop_cost_out),
    .count             (count)
`ifdef ACT_DENSE_REG_STATS_EN
    ,
    .xfer_count        (xfer_count),
    .drop_count        (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  beat_t       q[$];
  int unsigned m_xfer = 0;
  int unsigned m_drop = 0;
  bit          last_acc = 0;
  int          errors = 0;
  int          checks = 0;

  beat_t out_fields;
  assign out_fields = {act_type_out, dense_type_out, grad_out, w_layer_index_out,
                       w_row_index_out, is_update_out, backprop_cost_out};

  function automatic beat_t mk_beat(input logic [31:0] row, input bit upd, input bit cost);
    beat_t b;
    b.act   = 4'($urandom);
    b.dense = 4'($urandom);
    b.grad  = {16'($urandom), 16'($urandom), 16'($urandom)};
    b.layer = $urandom;
    b.row   = row;
    b.upd   = upd;
    b.cost  = cost;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    beat_t head;
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      head = q[0];
      checks++;
      assert (out_fields === head) else begin
        errors++;
        $error("FAIL %s.head observed=%0h expected=%0h", tag, out_fields, head);
      end
    end
`ifdef ACT_DENSE_REG_STATS_EN
    chk({tag, ".xfer_count"}, 64'(xfer_count), 64'(m_xfer));
    chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
`endif
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".count"}, 64'(count), 64'd0);
    checks++;
    assert (out_fields === '0) else begin
      errors++;
      $error("FAIL %s.fields observed=%0h expected=0", tag, out_fields);
    end
  endtask

  // One clock edge: predict from pre-edge model state, then compare after it.
  task automatic step(input string tag);
    bit acc, st, pp;
    beat_t b;
    b  = cur;
    acc = in_valid && (q.size() < DEPTH);
    st  = acc && (b.upd || b.cost);
    pp  = (q.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    last_acc = acc && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) begin
        void'(q.pop_front());
        m_xfer++;
      end
      if (st) q.push_back(b);
      if (acc && !st) m_drop++;
    end
    check_state(tag);
  endtask

  initial begin
    // Reset state, checked while reset is held and before any edge
    #3;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("post_reset");

    // Single beat
    cur = '0;
    cur.grad = {16'h0003, 16'h0002, 16'h0001};
    cur.layer = 32'd2;
    cur.row = 32'd5;
    cur.upd = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step("single.accept");
    chk("single.visible", 64'(out_valid), 64'd1);
    chk("single.row", 64'(w_row_index_out), 64'd5);
    in_valid = 1'b0;
    step("single.drain");
    chk("single.empty", 64'(count), 64'd0);

    // Fill then stall: three beats offered, two fit
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = mk_beat(32'(i), 1'b1, 1'b0);
      in_valid = 1'b1;
      step("fill");
      if (i == 2) chk("fill.held", 64'(last_acc), 64'd0);
    end
    chk("fill.count", 64'(count), 64'd2);
    chk("fill.in_ready", 64'(in_ready), 64'd0);
    chk("fill.head_row0", 64'(w_row_index_out), 64'd0);
    out_ready = 1'b1;
    step("stall.pop0");
    chk("stall.head_row1", 64'(w_row_index_out), 64'd1);
    step("stall.accept2");
    chk("stall.third_taken", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    step("stall.drain1");
    step("stall.drain2");

    // Bubble
    cur = mk_beat(32'd77, 1'b0, 1'b0);
    in_valid = 1'b1;
    step("bubble");
    chk("bubble.consumed", 64'(last_acc), 64'd1);
    chk("bubble.count", 64'(count), 64'd0);
    in_valid = 1'b0;

    // Streaming at count=1
    out_ready = 1'b0;
    cur = mk_beat(32'd100, 1'b0, 1'b1);
    in_valid = 1'b1;
    step("stream.prime");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur = mk_beat(32'(101 + i), 1'b1, 1'b1);
      step("stream");
      chk("stream.count1", 64'(count), 64'd1);
      chk("stream.head", 64'(w_row_index_out), 64'(101 + i));
    end
    in_valid = 1'b0;
    step("stream.drain");

    // Flush at count=2 with a same-cycle beat
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cur = mk_beat(32'(200 + i), 1'b1, 1'b0);
      in_valid = 1'b1;
      step("flush.fill");
    end
    cur = mk_beat(32'd299, 1'b1, 1'b0);
    flush = 1'b1;
    step("flush.edge");
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step("flush.after");
    chk("flush.absent", 64'(out_valid), 64'd0);

    // Async reset mid-cycle with count=2
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cur = mk_beat(32'(300 + i), 1'b0, 1'b1);
      in_valid = 1'b1;
      step("areset.fill");
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("areset.immediate");
    q.delete();
    m_xfer = 0;
    m_drop = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("areset.release");
    cur = mk_beat(32'd400, 1'b1, 1'b0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step("areset.push");
    in_valid = 1'b0;
    step("areset.pop");

    // Randomized traffic; a refused beat is held unchanged until taken
    cur = mk_beat($urandom, 1'b1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      int r;
      if (!in_valid || last_acc) begin
        r = $urandom_range(0, 3);
        cur = mk_beat($urandom, (r == 1) || (r == 3), r >= 2);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step("random");
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
